// File: rtl/sn76489_pkg.sv
// Shared definitions for the SN76489 timed command queue: FSM states, entry layout, status bits.
package sn76489_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int ENTRY_W        = 9;
  localparam int ENTRY_WAIT_BIT = 8;

  localparam int STAT_FULL  = 7;
  localparam int STAT_EMPTY = 6;
  localparam int STAT_OVF   = 5;

  localparam logic ADR_DATA = 1'b0;
  localparam logic ADR_WAIT = 1'b1;

  // Fill level as reported in the 5-bit status field, saturating at 31.
  function automatic logic [4:0] sat_level(input logic [8:0] lvl);
    return (lvl > 9'd31) ? 5'd31 : lvl[4:0];
  endfunction

endpackage

// File: rtl/sn76489_cmd_fifo.sv
// Synchronous DEPTH x 9 command FIFO; only pointers and count are reset, storage is not.
module sn76489_cmd_fifo
  import sn76489_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [ENTRY_W-1:0]           din,
  input  logic                         pop,
  output logic [ENTRY_W-1:0]           dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LW     = ADDR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wptr, rptr;
  logic [LW-1:0]      cnt;
  logic               do_push, do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = mem[rptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + ADDR_W'(1);
      if (do_pop)  rptr <= rptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sn76489_cmdq_wb8.sv
// Timed PSG command queue: Wishbone slave pushes bytes/waits, FSM replays them as PSG master writes.
// Optional SN76489_CMDQ_IRQ_EN adds O_irq, a refill request while playback is in progress.
module sn76489_cmdq_wb8
  import sn76489_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TICK_DIVIDE = 1134
) (
  input  logic       I_wb_clk,
  input  logic       I_reset_n,
  input  logic       I_wb_stb,
  input  logic       I_wb_we,
  input  logic       I_wb_adr,
  input  logic [7:0] I_wb_dat,
  output logic [7:0] O_wb_dat,
  output logic       O_wb_ack,
  output logic       O_psg_stb,
  output logic       O_psg_we,
  output logic [7:0] O_psg_dat,
  input  logic       I_psg_ack
`ifdef SN76489_CMDQ_IRQ_EN
  ,
  output logic       O_irq
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TW     = $clog2(TICK_DIVIDE);

  logic [ENTRY_W-1:0] head;
  logic [ADDR_W:0]    level;
  logic               fifo_full, fifo_empty;
  logic               push_req, read_done, pop, tick, overflow;
  logic [TW-1:0]      tcnt;
  logic [7:0]         wcnt;
  logic [7:0]         status;
  state_t             state;

  assign push_req  = I_wb_stb & I_wb_we & ~O_wb_ack;
  assign read_done = I_wb_stb & ~I_wb_we & O_wb_ack;
  assign pop       = (state == ST_IDLE) & ~fifo_empty;
  assign tick      = (tcnt == '0);
  assign O_psg_we  = 1'b1;
  assign status    = {fifo_full, fifo_empty, overflow, sat_level(9'(level))};

  sn76489_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (I_wb_clk),
    .rst_n (I_reset_n),
    .push  (push_req),
    .din   ({(I_wb_adr == ADR_WAIT), I_wb_dat}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Slave side: zero-wait-state ack, status sampled every cycle so a read returns it with ack.
  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      O_wb_ack <= 1'b0;
      O_wb_dat <= 8'h40;
      overflow <= 1'b0;
    end else begin
      O_wb_ack <= I_wb_stb;
      O_wb_dat <= status;
      if (push_req && fifo_full) overflow <= 1'b1;
      else if (read_done)        overflow <= 1'b0;
    end
  end

  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) tcnt <= '0;
    else            tcnt <= tick ? TW'(TICK_DIVIDE - 1) : tcnt - TW'(1);
  end

  // state | meaning
  // IDLE  | pop next entry; a wait of 0 is consumed here in one cycle
  // WRITE | PSG strobe held with data until the PSG acks
  // WAIT  | count down wcnt on tick pulses, back to IDLE when it reaches 0
  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state     <= ST_IDLE;
      wcnt      <= 8'd0;
      O_psg_stb <= 1'b0;
      O_psg_dat <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head[ENTRY_WAIT_BIT]) begin
              if (head[7:0] != 8'd0) begin
                state <= ST_WAIT;
                wcnt  <= head[7:0];
              end
            end else begin
              state     <= ST_WRITE;
              O_psg_dat <= head[7:0];
              O_psg_stb <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (I_psg_ack) begin
            O_psg_stb <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (tick) begin
            wcnt <= wcnt - 8'd1;
            if (wcnt == 8'd1) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SN76489_CMDQ_IRQ_EN
  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) O_irq <= 1'b0;
    else O_irq <= (level <= (ADDR_W + 1)'(DEPTH / 4)) && !((state == ST_IDLE) && fifo_empty);
  end
`endif

endmodule

// File: tb/tb_sn76489_cmdq_wb8.sv
// Self-checking bench for sn76489_cmdq_wb8 with a simple PSG responder and a write scoreboard.
module tb_sn76489_cmdq_wb8;

  localparam int T     = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0, we = 1'b0, adr = 1'b0;
  logic [7:0] wdat = 8'd0;
  logic [7:0] rdat;
  logic       ack;
  logic       psg_stb, psg_we;
  logic [7:0] psg_dat;
  logic       psg_ack;
  logic       psg_hold = 1'b0;
`ifdef SN76489_CMDQ_IRQ_EN
  logic       irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] wr_q[$];
  int         ack_cyc[$];
  int         rise_cyc[$];
  logic       prev_stb = 1'b0, prev_ack = 1'b0;
  logic [7:0] prev_dat = 8'd0;
  bit         hold_bad = 1'b0;

  sn76489_cmdq_wb8 #(.DEPTH(DEPTH), .TICK_DIVIDE(T)) dut (
    .I_wb_clk  (clk),
    .I_reset_n (rst_n),
    .I_wb_stb  (stb),
    .I_wb_we   (we),
    .I_wb_adr  (adr),
    .I_wb_dat  (wdat),
    .O_wb_dat  (rdat),
    .O_wb_ack  (ack),
    .O_psg_stb (psg_stb),
    .O_psg_we  (psg_we),
    .O_psg_dat (psg_dat),
    .I_psg_ack (psg_ack)
`ifdef SN76489_CMDQ_IRQ_EN
    ,
    .O_irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  // PSG responder: ack one cycle after strobe unless held off.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) psg_ack <= 1'b0;
    else        psg_ack <= psg_stb & ~psg_ack & ~psg_hold;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (psg_stb && psg_ack) begin
        wr_q.push_back(psg_dat);
        ack_cyc.push_back(cyc);
      end
      if (psg_stb && !prev_stb) rise_cyc.push_back(cyc);
      if (prev_stb && !prev_ack && (!psg_stb || psg_dat != prev_dat)) hold_bad <= 1'b1;
    end
    prev_stb <= psg_stb;
    prev_ack <= psg_ack;
    prev_dat <= psg_dat;
  end

  task automatic wb_xfer(input logic w, input logic a, input logic [7:0] d, output logic [7:0] r);
    @(negedge clk);
    stb = 1'b1; we = w; adr = a; wdat = d;
    @(negedge clk);
    r = rdat;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic push_data(input logic [7:0] d);
    logic [7:0] r;
    wb_xfer(1'b1, 1'b0, d, r);
  endtask

  task automatic push_wait(input logic [7:0] n);
    logic [7:0] r;
    wb_xfer(1'b1, 1'b1, n, r);
  endtask

  task automatic read_status(output logic [7:0] r);
    wb_xfer(1'b0, 1'b1, 8'h00, r);
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 3000 && wr_q.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    ack_cyc.delete();
    rise_cyc.delete();
    hold_bad = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    bit bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 1'b0)     begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (psg_stb !== 1'b0) begin errors++; $display("FAIL reset_psg_stb got %b want 0", psg_stb); end
    checks++; if (psg_dat !== 8'h00) begin errors++; $display("FAIL reset_psg_dat got %h want 00", psg_dat); end
    checks++; if (rdat !== 8'h40)   begin errors++; $display("FAIL reset_wb_dat got %h want 40", rdat); end
    rst_n = 1'b1;
    clear_mon();
    read_status(r);
    checks++; if (r !== 8'h40) begin errors++; $display("FAIL reset_status got %h want 40", r); end
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (psg_stb !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad || wr_q.size() != 0) begin errors++; $display("FAIL idle_quiet got stb_seen=%0d writes=%0d want 0 0", bad, wr_q.size()); end
  endtask

  task automatic test_two_writes();
    logic [7:0] r;
    clear_mon();
    push_data(8'h9F);
    push_data(8'h8E);
    wait_writes(2);
    checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL two_count got %0d want 2", wr_q.size()); end
    else begin
      checks++; if (wr_q[0] !== 8'h9F) begin errors++; $display("FAIL two_first got %h want 9f", wr_q[0]); end
      checks++; if (wr_q[1] !== 8'h8E) begin errors++; $display("FAIL two_second got %h want 8e", wr_q[1]); end
    end
    checks++; if (hold_bad) begin errors++; $display("FAIL two_hold got stb/dat change before ack want held"); end
    checks++; if (psg_stb !== 1'b0 || psg_we !== 1'b1) begin errors++; $display("FAIL two_idle got stb=%b we=%b want 0 1", psg_stb, psg_we); end
    read_status(r);
    checks++; if (r !== 8'h40) begin errors++; $display("FAIL two_status got %h want 40", r); end
  endtask

  // Fixed handshake overhead around a wait: 4 cycles (pop wait, pop data, strobe, ack).
  task automatic test_wait_gap();
    for (int round = 0; round < 3; round++) begin
      int n, gap;
      logic [7:0] d1, d2;
      n  = $urandom_range(1, 4);
      d1 = 8'($urandom_range(0, 255));
      d2 = 8'($urandom_range(0, 255));
      clear_mon();
      push_data(d1);
      push_wait(8'(n));
      push_data(d2);
      wait_writes(2);
      checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL gap_count got %0d want 2", wr_q.size()); end
      else begin
        gap = ack_cyc[1] - ack_cyc[0] - 4;
        checks++; if (wr_q[0] !== d1 || wr_q[1] !== d2) begin errors++; $display("FAIL gap_data got %h %h want %h %h", wr_q[0], wr_q[1], d1, d2); end
        checks++; if (gap < (n - 1) * T || gap > n * T) begin errors++; $display("FAIL gap_delay got %0d want %0d..%0d (n=%0d)", gap, (n - 1) * T, n * T, n); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes[18];
    logic [7:0] r, exp;
    int stored, dropped;
    clear_mon();
    psg_hold = 1'b1;
    foreach (bytes[i]) begin
      bytes[i] = 8'($urandom_range(0, 255));
      push_data(bytes[i]);
    end
    // First byte goes straight into the stalled write; the rest compete for DEPTH slots.
    stored  = (18 - 1 > DEPTH) ? DEPTH : 18 - 1;
    dropped = 18 - 1 - stored;
    exp = {stored == DEPTH, stored == 0, dropped > 0, 5'(stored > 31 ? 31 : stored)};
    read_status(r);
    checks++; if (r !== exp || r !== 8'hB0) begin errors++; $display("FAIL ovf_status got %h want %h", r, exp); end
    exp[5] = 1'b0;
    read_status(r);
    checks++; if (r !== exp) begin errors++; $display("FAIL ovf_clear got %h want %h", r, exp); end
    checks++; if (wr_q.size() != 0 || psg_dat !== bytes[0]) begin errors++; $display("FAIL ovf_stall got writes=%0d dat=%h want 0 %h", wr_q.size(), psg_dat, bytes[0]); end
    psg_hold = 1'b0;
    wait_writes(stored + 1);
    checks++; if (wr_q.size() != stored + 1) begin errors++; $display("FAIL ovf_drain got %0d want %0d", wr_q.size(), stored + 1); end
    else begin
      for (int i = 0; i <= stored; i++) begin
        checks++; if (wr_q[i] !== bytes[i]) begin errors++; $display("FAIL ovf_order[%0d] got %h want %h", i, wr_q[i], bytes[i]); end
      end
    end
    read_status(r);
    checks++; if (r !== 8'h40) begin errors++; $display("FAIL ovf_final got %h want 40", r); end
  endtask

  task automatic test_wait_zero();
    logic [7:0] d0;
    int delta;
    d0 = 8'($urandom_range(0, 255));
    clear_mon();
    psg_hold = 1'b1;
    push_data(d0);
    push_wait(8'd0);
    push_data(8'h81);
    psg_hold = 1'b0;
    wait_writes(2);
    checks++; if (wr_q.size() != 2 || rise_cyc.size() != 2) begin errors++; $display("FAIL wz_count got %0d/%0d want 2/2", wr_q.size(), rise_cyc.size()); end
    else begin
      delta = rise_cyc[1] - (ack_cyc[0] + 1);
      checks++; if (wr_q[0] !== d0 || wr_q[1] !== 8'h81) begin errors++; $display("FAIL wz_data got %h %h want %h 81", wr_q[0], wr_q[1], d0); end
      checks++; if (delta < 1 || delta > 3) begin errors++; $display("FAIL wz_latency got %0d want 1..3", delta); end
    end
  endtask

  task automatic test_random_stream();
    for (int round = 0; round < 2; round++) begin
      logic [7:0] exp[$];
      logic [7:0] d;
      clear_mon();
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 3) == 0) push_wait(8'($urandom_range(0, 2)));
        else begin
          d = 8'($urandom_range(0, 255));
          exp.push_back(d);
          push_data(d);
        end
      end
      wait_writes(exp.size());
      checks++; if (wr_q.size() != exp.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", wr_q.size(), exp.size()); end
      else begin
        for (int i = 0; i < exp.size(); i++) begin
          checks++; if (wr_q[i] !== exp[i]) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", i, wr_q[i], exp[i]); end
        end
      end
      checks++; if (hold_bad) begin errors++; $display("FAIL rnd_hold got stb/dat change before ack want held"); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] r;
    clear_mon();
    psg_hold = 1'b1;
    push_data(8'($urandom_range(0, 255)));
    for (int i = 0; i < 20 && !psg_stb; i++) @(negedge clk);
    checks++; if (psg_stb !== 1'b1) begin errors++; $display("FAIL rst_pre got stb=%b want 1", psg_stb); end
    push_data(8'h9F);
    push_data(8'h8E);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (psg_stb !== 1'b0) begin errors++; $display("FAIL rst_async got stb=%b want 0", psg_stb); end
    psg_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (wr_q.size() != 0 || psg_stb !== 1'b0) begin errors++; $display("FAIL rst_lost got writes=%0d stb=%b want 0 0", wr_q.size(), psg_stb); end
    read_status(r);
    checks++; if (r !== 8'h40) begin errors++; $display("FAIL rst_status got %h want 40", r); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_writes();
    test_wait_gap();
    test_overflow();
    test_wait_zero();
    test_random_stream();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
